// File: rtl/i2c_fifo_pkg.sv
// Purpose: shared I2C slave constants and the FIFO status word layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_fifo_pkg;

    localparam int I2C_DW         = 32;
    localparam int FIFO_AW        = 4;
    localparam int FIFO_AFULL_LVL = 12;

    // Bit positions used by the register block when it maps FIFO status.
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_AFULL     = 2;
    localparam int ST_UNDERFLOW = 3;
    localparam int ST_OVERFLOW  = 4;

    // Field order matches the bit positions above (empty is bit 0).
    typedef struct packed {
        logic overflow;
        logic underflow;
        logic almost_full;
        logic full;
        logic empty;
    } fifo_status_t;

endpackage

// File: rtl/i2c_fifo_if.sv
// Purpose: push/pop data and status bundle between a FIFO user and i2c_fifo.
// Latency: n/a (wires only).
// Backpressure: user observes full/empty; the FIFO flags refused requests as errors.
// Ports: push/din/pop/flush/err_clr driven by master; dout, level and
//        status flags driven by the FIFO (slave).
interface i2c_fifo_if #(
    parameter int DW = i2c_fifo_pkg::I2C_DW,
    parameter int AW = i2c_fifo_pkg::FIFO_AW
);
    logic          push;
    logic [DW-1:0] din;
    logic          pop;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   level;
    logic          flush;
    logic          err_clr;
    logic          overflow;
    logic          underflow;

    modport master (
        output push, din, pop, flush, err_clr,
        input  dout, full, empty, almost_full, level, overflow, underflow
    );

    modport slave (
        input  push, din, pop, flush, err_clr,
        output dout, full, empty, almost_full, level, overflow, underflow
    );
endinterface

// File: rtl/i2c_fifo_ram.sv
// Purpose: simple dual-port storage, synchronous write, asynchronous read.
// Latency: write lands on the clock edge; read data is combinational from raddr.
// Backpressure: none; the caller gates we.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
module i2c_fifo_ram
    import i2c_fifo_pkg::*;
#(
    parameter int DW = I2C_DW,
    parameter int AW = FIFO_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    // No reset on the array so it maps onto distributed RAM.
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_fifo.sv
// Purpose: 32-bit first-word-fall-through word FIFO with level and sticky error status.
// Latency: pushed word visible on dout one edge after push; next word visible one edge after pop.
// Backpressure: push while full (without pop) is dropped and sets overflow; pop while empty sets underflow.
// Ports: clk, rst (sync, active-high), bus (i2c_fifo_if.slave: push/din, pop/dout,
//        flush, err_clr, level, full, empty, almost_full, overflow, underflow).
module i2c_fifo
    import i2c_fifo_pkg::*;
#(
    parameter int DW        = I2C_DW,
    parameter int AW        = FIFO_AW,
    parameter int AFULL_LVL = FIFO_AFULL_LVL
) (
    input  logic      clk,
    input  logic      rst,
    i2c_fifo_if.slave bus
);
    localparam int            LW    = AW + 1;
    localparam logic [LW-1:0] DEPTH = LW'(2**AW);
    localparam logic [LW-1:0] AFULL = LW'(AFULL_LVL);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    fifo_status_t  st_q;
    logic          push_ok;
    logic          pop_ok;
    logic          ram_we;

    // Acceptance uses registered flags only, so status outputs never see a
    // combinational path from push/pop.
    always_comb begin
        push_ok   = bus.push & (~st_q.full | bus.pop);
        pop_ok    = bus.pop & ~st_q.empty;
        level_nxt = level_q + LW'(push_ok) - LW'(pop_ok);
        if (bus.flush) begin
            level_nxt = '0;
        end
    end

    // Flush discards the incoming word too.
    assign ram_we = push_ok & ~bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            st_q    <= '{overflow: 1'b0, underflow: 1'b0, almost_full: 1'b0,
                         full: 1'b0, empty: 1'b1};
        end else begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
            level_q          <= level_nxt;
            // Flags follow the next level so they move on the same edge as level.
            st_q.empty       <= (level_nxt == '0);
            st_q.full        <= (level_nxt == DEPTH);
            st_q.almost_full <= (level_nxt >= AFULL);
            // Sticky errors: a new event in the clearing cycle wins; flush leaves them alone.
            st_q.overflow    <= (bus.push & ~push_ok) | (st_q.overflow & ~bus.err_clr);
            st_q.underflow   <= (bus.pop & st_q.empty) | (st_q.underflow & ~bus.err_clr);
        end
    end

    i2c_fifo_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .raddr (rd_ptr),
        .rdata (bus.dout)
    );

    assign bus.level       = level_q;
    assign bus.full        = st_q.full;
    assign bus.empty       = st_q.empty;
    assign bus.almost_full = st_q.almost_full;
    assign bus.overflow    = st_q.overflow;
    assign bus.underflow   = st_q.underflow;

endmodule
